// File: rtl/xadc_drp_axis_sequencer_if.sv
// AXI-Stream bundle for the XADC sequencer output.
// Source drives payload and tvalid and samples tready. Sink is the mirror image.
// master and slave are aliases of Source and Sink.
interface axis_interface #(
   parameter int DATA_WIDTH = 16,
   parameter int ID_WIDTH   = 4,
   parameter int USER_WIDTH = 1,
   parameter int DEST_WIDTH = 1
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;
   logic [ID_WIDTH-1:0]     tid;
   logic [DEST_WIDTH-1:0]   tdest;
   logic [USER_WIDTH-1:0]   tuser;

   modport Source (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
   modport Sink   (input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
   modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
   modport slave  (input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/xadc_drp_axis_sequencer.sv
// xadc_drp_axis_sequencer: on every XADC end-of-sequence pulse, reads a list of
// DRP status registers and emits one tagged AXI-Stream beat per register.
// All logic runs in the xadc_dclk domain.
// Optional feature macro: XADC_DRP_SEQ_TIMEOUT_EN enables the DRDY timeout path.
module xadc_drp_axis_sequencer #(
   parameter int                              NUM_CHANNELS  = 2,
   parameter logic [0:NUM_CHANNELS-1][6:0]    CHANNEL_ADDRS = {7'h13, 7'h03},
   parameter int                              DRP_TIMEOUT   = 64
) (
   input  logic          xadc_dclk,
   input  logic          xadc_reset_n,
   output logic [6:0]    xadc_daddr,
   output logic          xadc_den,
   input  logic          xadc_drdy,
   input  logic [15:0]   xadc_do,
   input  logic          xadc_eos,
   axis_interface.Source sample,
   output logic [15:0]   overrun_count,
   output logic [15:0]   timeout_count
);

   typedef enum logic [1:0] {
      AWAIT_EOS = 2'd0,
      DRP_ISSUE = 2'd1,
      DRP_WAIT  = 2'd2,
      AXIS_SEND = 2'd3
   } state_t;

   localparam logic [3:0] LAST_CH = 4'(NUM_CHANNELS - 1);

   // Look up a channel address by index. The loop avoids indexing the table
   // with a wider-than-needed index when NUM_CHANNELS is small.
   function automatic logic [6:0] addr_of(input logic [3:0] idx);
      logic [6:0] a;
      a = CHANNEL_ADDRS[0];
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         a = (idx == 4'(i)) ? CHANNEL_ADDRS[i] : a;
      end
      return a;
   endfunction

   // Increment a 16-bit counter that sticks at all ones.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  ch_q, ch_d;
   logic [6:0]  daddr_q, daddr_d;
   logic        den_q, den_d;
   logic [15:0] tdata_q, tdata_d;
   logic [3:0]  tid_q, tid_d;
   logic        tlast_q, tlast_d;
   logic        tuser_q, tuser_d;
   logic        tvalid_q, tvalid_d;
   logic [15:0] ovr_q, ovr_d;

`ifdef XADC_DRP_SEQ_TIMEOUT_EN
   localparam int            TW     = $clog2(DRP_TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(DRP_TIMEOUT - 1);
   logic [TW-1:0] wait_cnt_q, wait_cnt_d;
   logic [15:0]   tmo_q, tmo_d;
`endif

   // Next-state, DRP request and beat payload logic.
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      daddr_d  = daddr_q;
      den_d    = 1'b0;
      tdata_d  = tdata_q;
      tid_d    = tid_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      tvalid_d = tvalid_q;
`ifdef XADC_DRP_SEQ_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
      tmo_d      = tmo_q;
`endif

      // An EOS outside the idle state is dropped but counted; the sweep continues.
      if (xadc_eos && (state_q != AWAIT_EOS)) begin
         ovr_d = sat_inc(ovr_q);
      end else begin
         ovr_d = ovr_q;
      end

      case (state_q)
         AWAIT_EOS: begin
            if (xadc_eos) begin
               ch_d    = 4'd0;
               daddr_d = addr_of(4'd0);
               den_d   = 1'b1;
               state_d = DRP_ISSUE;
            end else begin
               state_d = AWAIT_EOS;
            end
         end
         DRP_ISSUE: begin
            state_d = DRP_WAIT;
`ifdef XADC_DRP_SEQ_TIMEOUT_EN
            wait_cnt_d = {TW{1'b0}};
`endif
         end
         DRP_WAIT: begin
            // DRDY wins over an expiry in the same cycle.
            if (xadc_drdy) begin
               tdata_d  = xadc_do;
               tid_d    = ch_q;
               tlast_d  = (ch_q == LAST_CH);
               tuser_d  = 1'b0;
               tvalid_d = 1'b1;
               state_d  = AXIS_SEND;
`ifdef XADC_DRP_SEQ_TIMEOUT_EN
            end else if (wait_cnt_q == T_LAST) begin
               tdata_d  = 16'h0000;
               tid_d    = ch_q;
               tlast_d  = (ch_q == LAST_CH);
               tuser_d  = 1'b1;
               tvalid_d = 1'b1;
               tmo_d    = sat_inc(tmo_q);
               state_d  = AXIS_SEND;
            end else begin
               wait_cnt_d = wait_cnt_q + {{(TW-1){1'b0}}, 1'b1};
`else
            end else begin
               state_d = DRP_WAIT;
`endif
            end
         end
         AXIS_SEND: begin
            if (tvalid_q && sample.tready) begin
               tvalid_d = 1'b0;
               if (tlast_q) begin
                  state_d = AWAIT_EOS;
               end else begin
                  ch_d    = ch_q + 4'd1;
                  daddr_d = addr_of(ch_q + 4'd1);
                  den_d   = 1'b1;
                  state_d = DRP_ISSUE;
               end
            end else begin
               state_d = AXIS_SEND;
            end
         end
         default: begin
            state_d  = AWAIT_EOS;
            tvalid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge xadc_dclk) begin
      if (!xadc_reset_n) begin
         state_q  <= AWAIT_EOS;
         ch_q     <= 4'd0;
         daddr_q  <= CHANNEL_ADDRS[0];
         den_q    <= 1'b0;
         tdata_q  <= 16'h0000;
         tid_q    <= 4'd0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         tvalid_q <= 1'b0;
         ovr_q    <= 16'h0000;
`ifdef XADC_DRP_SEQ_TIMEOUT_EN
         wait_cnt_q <= {TW{1'b0}};
         tmo_q      <= 16'h0000;
`endif
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         daddr_q  <= daddr_d;
         den_q    <= den_d;
         tdata_q  <= tdata_d;
         tid_q    <= tid_d;
         tlast_q  <= tlast_d;
         tuser_q  <= tuser_d;
         tvalid_q <= tvalid_d;
         ovr_q    <= ovr_d;
`ifdef XADC_DRP_SEQ_TIMEOUT_EN
         wait_cnt_q <= wait_cnt_d;
         tmo_q      <= tmo_d;
`endif
      end
   end

   assign xadc_daddr    = daddr_q;
   assign xadc_den      = den_q;
   assign overrun_count = ovr_q;
`ifdef XADC_DRP_SEQ_TIMEOUT_EN
   assign timeout_count = tmo_q;
`else
   assign timeout_count = 16'h0000;
`endif

   assign sample.tdata  = tdata_q;
   assign sample.tkeep  = 2'b11;
   assign sample.tvalid = tvalid_q;
   assign sample.tlast  = tlast_q;
   assign sample.tid    = tid_q;
   assign sample.tdest  = 1'b0;
   assign sample.tuser  = tuser_q;

endmodule

// File: tb/tb_xadc_drp_axis_sequencer.sv
// Directed bench for xadc_drp_axis_sequencer: a three-channel instance and a
// one-channel instance, each with a behavioural DRP responder (data = 0x1000+addr).
module tb_xadc_drp_axis_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic eos   = 1'b0;
   logic eos1  = 1'b0;

   int errors = 0;
   int checks = 0;

   // ---------------- three-channel DUT ----------------
   logic [6:0]  daddr3;
   logic        den3;
   logic        drdy3 = 1'b0;
   logic [15:0] do3   = 16'h0000;
   logic [15:0] ovr3, tmo3;
   axis_interface #(.DATA_WIDTH(16)) s3 ();

   xadc_drp_axis_sequencer #(
      .NUM_CHANNELS (3),
      .CHANNEL_ADDRS({7'h13, 7'h03, 7'h1E}),
      .DRP_TIMEOUT  (8)
   ) dut3 (
      .xadc_dclk    (clk),
      .xadc_reset_n (rst_n),
      .xadc_daddr   (daddr3),
      .xadc_den     (den3),
      .xadc_drdy    (drdy3),
      .xadc_do      (do3),
      .xadc_eos     (eos),
      .sample       (s3),
      .overrun_count(ovr3),
      .timeout_count(tmo3)
   );

   // ---------------- one-channel DUT ----------------
   logic [6:0]  daddr1;
   logic        den1;
   logic        drdy1 = 1'b0;
   logic [15:0] do1   = 16'h0000;
   logic [15:0] ovr1, tmo1;
   axis_interface #(.DATA_WIDTH(16)) s1 ();

   xadc_drp_axis_sequencer #(
      .NUM_CHANNELS (1),
      .CHANNEL_ADDRS(7'h1E),
      .DRP_TIMEOUT  (8)
   ) dut1 (
      .xadc_dclk    (clk),
      .xadc_reset_n (rst_n),
      .xadc_daddr   (daddr1),
      .xadc_den     (den1),
      .xadc_drdy    (drdy1),
      .xadc_do      (do1),
      .xadc_eos     (eos1),
      .sample       (s1),
      .overrun_count(ovr1),
      .timeout_count(tmo1)
   );

   // DRP responders: answer 4 edges after DEN; optionally never answer one address.
   logic       block_en   = 1'b0;
   logic [6:0] block_addr = 7'h03;
   logic [2:0] pend3 = 3'd0, pend1 = 3'd0;
   logic [6:0] paddr3 = 7'h00, paddr1 = 7'h00;

   always @(posedge clk) begin
      drdy3 <= 1'b0;
      if (den3) begin
         if (!(block_en && (daddr3 == block_addr))) begin
            pend3  <= 3'd4;
            paddr3 <= daddr3;
         end
      end else if (pend3 > 3'd1) begin
         pend3 <= pend3 - 3'd1;
      end else if (pend3 == 3'd1) begin
         pend3 <= 3'd0;
         drdy3 <= 1'b1;
         do3   <= 16'h1000 + {9'd0, paddr3};
      end
   end

   always @(posedge clk) begin
      drdy1 <= 1'b0;
      if (den1) begin
         pend1  <= 3'd4;
         paddr1 <= daddr1;
      end else if (pend1 > 3'd1) begin
         pend1 <= pend1 - 3'd1;
      end else if (pend1 == 3'd1) begin
         pend1 <= 3'd0;
         drdy1 <= 1'b1;
         do1   <= 16'h1000 + {9'd0, paddr1};
      end
   end

   // Monitors: record handshaken beats, DEN pulses and tvalid rise times.
   int          cyc = 0, beat_n3 = 0, den_n3 = 0, rise3 = 0, beat_n1 = 0;
   logic        prev_v3 = 1'b0;
   logic [15:0] b_data[64];
   logic [3:0]  b_id[64];
   logic        b_last[64];
   logic        b_user[64];
   int          b_rise[64];
   int          den_cyc[64];
   logic [15:0] c_data[64];
   logic [3:0]  c_id[64];
   logic        c_last[64];

   always @(negedge clk) begin
      cyc     <= cyc + 1;
      prev_v3 <= s3.tvalid;
      if (s3.tvalid && !prev_v3) rise3 <= cyc;
      if (den3 && den_n3 < 64) begin
         den_cyc[den_n3] <= cyc;
         den_n3          <= den_n3 + 1;
      end
      if (s3.tvalid && s3.tready && beat_n3 < 64) begin
         b_data[beat_n3] <= s3.tdata;
         b_id[beat_n3]   <= s3.tid;
         b_last[beat_n3] <= s3.tlast;
         b_user[beat_n3] <= s3.tuser[0];
         b_rise[beat_n3] <= prev_v3 ? rise3 : cyc;
         beat_n3         <= beat_n3 + 1;
      end
      if (s1.tvalid && s1.tready && beat_n1 < 64) begin
         c_data[beat_n1] <= s1.tdata;
         c_id[beat_n1]   <= s1.tid;
         c_last[beat_n1] <= s1.tlast;
         beat_n1         <= beat_n1 + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_eos();
      tick();
      eos = 1'b1;
      tick();
      eos = 1'b0;
   endtask

   task automatic wait_beats3(input int target, input string tag);
      int k = 0;
      while (beat_n3 < target && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(beat_n3 >= target), 32'd1);
   endtask

   task automatic wait_valid3(input string tag);
      int k = 0;
      while (!s3.tvalid && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(s3.tvalid), 32'd1);
   endtask

   task automatic chk_beat(input string tag, input int idx, input logic [15:0] d,
                           input logic [3:0] id, input logic last, input logic user);
      chk({tag, ".tdata"}, 32'(b_data[idx]), 32'(d));
      chk({tag, ".tid"},   32'(b_id[idx]),   32'(id));
      chk({tag, ".tlast"}, 32'(b_last[idx]), 32'(last));
      chk({tag, ".tuser"}, 32'(b_user[idx]), 32'(user));
   endtask

   int bb, db;

   initial begin
      s3.tready = 1'b1;
      s1.tready = 1'b1;

      // Reset state.
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.tvalid", 32'(s3.tvalid), 32'd0);
      chk("rst.daddr",  32'(daddr3), 32'h13);
      chk("rst.den",    32'(den3), 32'd0);
      chk("rst.tdata",  32'(s3.tdata), 32'h0);
      chk("rst.tid",    32'(s3.tid), 32'h0);
      chk("rst.tlast",  32'(s3.tlast), 32'd0);
      chk("rst.tuser",  32'(s3.tuser), 32'd0);
      chk("rst.ovr",    32'(ovr3), 32'h0);
      chk("rst.tmo",    32'(tmo3), 32'h0);
      chk("rst.daddr1", 32'(daddr1), 32'h1E);
      chk("rst.tkeep",  32'(s3.tkeep), 32'h3);
      chk("rst.tdest",  32'(s3.tdest), 32'h0);

      // Basic sweep, tready held high; DEN in the cycle after EOS.
      bb = beat_n3; db = den_n3;
      pulse_eos();
      chk("t1.den_latency", 32'(den3), 32'd1);
      chk("t1.daddr0", 32'(daddr3), 32'h13);
      wait_beats3(bb + 3, "t1.beats_done");
      chk_beat("t1.b0", bb + 0, 16'h1013, 4'd0, 1'b0, 1'b0);
      chk_beat("t1.b1", bb + 1, 16'h1003, 4'd1, 1'b0, 1'b0);
      chk_beat("t1.b2", bb + 2, 16'h101E, 4'd2, 1'b1, 1'b0);
      chk("t1.den_pulses", 32'(den_n3 - db), 32'd3);
      chk("t1.ovr", 32'(ovr3), 32'h0);

      // Stall beat 1 for 10 cycles: payload stable, no new DEN.
      bb = beat_n3; db = den_n3;
      pulse_eos();
      wait_beats3(bb + 1, "t2.beat0");
      s3.tready = 1'b0;
      wait_valid3("t2.beat1_valid");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2.stall.tvalid", 32'(s3.tvalid), 32'd1);
         chk("t2.stall.tdata",  32'(s3.tdata), 32'h1003);
         chk("t2.stall.tid",    32'(s3.tid), 32'd1);
         chk("t2.stall.tlast",  32'(s3.tlast), 32'd0);
      end
      chk("t2.stall.den", 32'(den_n3 - db), 32'd2);
      s3.tready = 1'b1;
      wait_beats3(bb + 3, "t2.beats_done");
      chk_beat("t2.b1", bb + 1, 16'h1003, 4'd1, 1'b0, 1'b0);
      chk_beat("t2.b2", bb + 2, 16'h101E, 4'd2, 1'b1, 1'b0);
      chk("t2.den_pulses", 32'(den_n3 - db), 32'd3);

      // Overrun: one extra EOS, then a long burst held during a stall.
      bb = beat_n3;
      s3.tready = 1'b0;
      pulse_eos();
      repeat (4) tick();
      pulse_eos();
      chk("t3.ovr_one", 32'(ovr3), 32'h1);
      tick();
      eos = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      eos = 1'b0;
      chk("t3.ovr_sat", 32'(ovr3), 32'hFFFF);
      s3.tready = 1'b1;
      wait_beats3(bb + 3, "t3.beats_done");
      chk_beat("t3.b0", bb + 0, 16'h1013, 4'd0, 1'b0, 1'b0);
      chk_beat("t3.b2", bb + 2, 16'h101E, 4'd2, 1'b1, 1'b0);
      repeat (30) @(negedge clk);
      chk("t3.no_extra_beats", 32'(beat_n3 - bb), 32'd3);
      chk("t3.ovr_hold", 32'(ovr3), 32'hFFFF);

`ifdef XADC_DRP_SEQ_TIMEOUT_EN
      // Channel 1 never answers: timeout beat, sweep continues.
      bb = beat_n3; db = den_n3;
      block_en = 1'b1;
      pulse_eos();
      wait_beats3(bb + 3, "t4.beats_done");
      chk_beat("t4.b0", bb + 0, 16'h1013, 4'd0, 1'b0, 1'b0);
      chk_beat("t4.b1", bb + 1, 16'h0000, 4'd1, 1'b0, 1'b1);
      chk_beat("t4.b2", bb + 2, 16'h101E, 4'd2, 1'b1, 1'b0);
      chk("t4.tmo", 32'(tmo3), 32'h1);
      // DEN in cycle c, eight wait cycles, tvalid visible in cycle c+9.
      chk("t4.timeout_delay", 32'(b_rise[bb + 1] - den_cyc[db + 1]), 32'd9);
      block_en = 1'b0;
`else
      chk("t4.tmo_tied", 32'(tmo3), 32'h0);
`endif

      // Reset while a beat is stalled in AXIS_SEND.
      s3.tready = 1'b0;
      pulse_eos();
      wait_valid3("t5.valid_before_reset");
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5.tvalid", 32'(s3.tvalid), 32'd0);
      chk("t5.daddr",  32'(daddr3), 32'h13);
      chk("t5.den",    32'(den3), 32'd0);
      chk("t5.ovr",    32'(ovr3), 32'h0);
      chk("t5.tmo",    32'(tmo3), 32'h0);
      chk("t5.tdata",  32'(s3.tdata), 32'h0);
      s3.tready = 1'b1;
      bb = beat_n3;
      pulse_eos();
      chk("t5.restart_den", 32'(den3), 32'd1);
      chk("t5.restart_daddr", 32'(daddr3), 32'h13);
      wait_beats3(bb + 3, "t5.beats_done");
      chk_beat("t5.b0", bb + 0, 16'h1013, 4'd0, 1'b0, 1'b0);
      chk_beat("t5.b2", bb + 2, 16'h101E, 4'd2, 1'b1, 1'b0);

      // One-channel instance: every beat is tid 0 with tlast.
      for (int s = 0; s < 2; s++) begin
         int b1 = beat_n1;
         int k  = 0;
         tick();
         eos1 = 1'b1;
         tick();
         eos1 = 1'b0;
         while (beat_n1 < b1 + 1 && k < 200) begin
            @(negedge clk);
            k++;
         end
         chk("t6.beat_seen", 32'(beat_n1 - b1), 32'd1);
         chk("t6.tdata", 32'(c_data[b1]), 32'h101E);
         chk("t6.tid",   32'(c_id[b1]), 32'd0);
         chk("t6.tlast", 32'(c_last[b1]), 32'd1);
         repeat (5) @(negedge clk);
      end
      chk("t6.ovr1", 32'(ovr1), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
